digit_compare_sequencer: RTL

- Compares two NUM_DIGITS-nibble operands, for example the current time against the alarm time (HHMMSS) in the digital clock.
- Uses one shared 4-bit nibble comparator, time-multiplexed MSB-first, instead of a cascade of NUM_DIGITS comparators.
- Start/busy/done handshake; the result is registered and held between operations.
- Sits between the clock/alarm registers and the alarm-match logic.

---
 rtl/digit_compare_sequencer_pkg.sv | 19 +
 rtl/digit_compare_sequencer_nibble_compare.sv | 12 +
 rtl/digit_compare_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/digit_compare_sequencer_pkg.sv
// Shared encodings for the digit compare sequencer: FSM states and one-hot result codes.
// Optional build macro used by the top: DIGIT_COMPARE_EARLY_EXIT_EN.
package digit_compare_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] res_t;

    // Result order is {gt, lt, eq}
    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_LT   = 3'b010;
    localparam res_t RES_EQ   = 3'b001;
    localparam res_t RES_NONE = 3'b000;

endpackage

// File: rtl/digit_compare_sequencer_nibble_compare.sv
// Combinational unsigned magnitude compare of two 4-bit digits.
module nibble_compare (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/digit_compare_sequencer.sv
// Compares two NUM_DIGITS-nibble operands MSB-first through one shared nibble comparator.
// Build option: define DIGIT_COMPARE_EARLY_EXIT_EN to finish on the first differing digit.
module digit_compare_sequencer
    import digit_compare_sequencer_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] op_a,
    input  logic [4*NUM_DIGITS-1:0] op_b,
    output logic                    busy,
    output logic                    done,
    output logic                    res_gt,
    output logic                    res_lt,
    output logic                    res_eq
);

    localparam int CNT_W = $clog2(NUM_DIGITS);

    // Handshake: start is accepted only while idle (busy=0, done=0); busy stays high for the
    // whole RUN phase and done pulses for one cycle with res_* already valid. No queuing.
    state_t                       state;
    state_t                       state_nxt;
    logic [CNT_W-1:0]             idx;
    logic [NUM_DIGITS-1:0][3:0]   a_q;
    logic [NUM_DIGITS-1:0][3:0]   b_q;
    res_t                         acc;
    res_t                         acc_nxt;
    res_t                         res_q;
    logic                         dig_gt;
    logic                         dig_lt;

    nibble_compare u_nibble_compare (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    // Once a higher digit has decided the result, lower digits can no longer change it.
    always_comb begin
        acc_nxt = acc;
        if (acc == RES_EQ) begin
            if (dig_gt) begin
                acc_nxt = RES_GT;
            end else if (dig_lt) begin
                acc_nxt = RES_LT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
`ifdef DIGIT_COMPARE_EARLY_EXIT_EN
                if (idx == '0 || acc_nxt != RES_EQ) begin
                    state_nxt = DONE;
                end
`else
                if (idx == '0) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= RES_NONE;
            res_q <= RES_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= op_a;
                        b_q <= op_b;
                        idx <= CNT_W'(NUM_DIGITS - 1);
                        acc <= RES_EQ;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end
                    // Results load on the edge entering DONE so they appear together with done.
                    if (state_nxt == DONE) begin
                        res_q <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {res_gt, res_lt, res_eq} = res_q;

endmodule
